// File: rtl/stim_stream_gen.sv
// Stimulus transmitter for the IIR filter input: sample RAM + coefficient file, paced playback, drain, END_SIM.
// Optional build macro STIM_RANDGAP_EN adds an LFSR-driven jitter of 0..3 cycles on each inter-sample gap.
module stim_stream_gen #(
  parameter int NB    = 12,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DRAIN = 8
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          START,
  input  logic [AW:0]   NSAMP,
  input  logic [3:0]    GAP,
  input  logic          LD_WE,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [NB-1:0] LD_DATA,
  input  logic          CFG_WE,
  input  logic [2:0]    CFG_SEL,
  input  logic [NB-1:0] CFG_DATA,
  output logic          VOUT,
  output logic [NB-1:0] DOUT,
  output logic [NB-1:0] a1,
  output logic [NB-1:0] a2,
  output logic [NB-1:0] b0,
  output logic [NB-1:0] b1,
  output logic [NB-1:0] b2,
  output logic          BUSY,
  output logic          END_SIM,
  output logic [1:0]    state_dbg
);

  localparam int DW = $clog2(DRAIN + 1);
`ifdef STIM_RANDGAP_EN
  localparam int GW = 6;
`else
  localparam int GW = 4;
`endif
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [NB-1:0] mem [DEPTH];
  logic [AW:0]   idx;
  logic [AW:0]   nsamp_q;
  logic [AW:0]   nsamp_clamped;
  logic [3:0]    gap_q;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_len;
  logic [DW-1:0] drain_cnt;

  assign state_dbg     = state;
  assign nsamp_clamped = (NSAMP > DEPTH_W) ? DEPTH_W : NSAMP;

`ifdef STIM_RANDGAP_EN
  logic [7:0] lfsr;
  assign gap_len = {2'b00, gap_q} + {4'b0000, lfsr[1:0]};
`else
  assign gap_len = gap_q;
`endif

  // RAM is only writable in IDLE, including the cycle START is sampled.
  always_ff @(posedge CLK) begin
    if (RST_n && state == S_IDLE && LD_WE) begin
      mem[LD_ADDR] <= LD_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state     <= S_IDLE;
      VOUT      <= 1'b0;
      DOUT      <= '0;
      a1        <= '0;
      a2        <= '0;
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
      BUSY      <= 1'b0;
      END_SIM   <= 1'b0;
      idx       <= '0;
      nsamp_q   <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      drain_cnt <= '0;
`ifdef STIM_RANDGAP_EN
      lfsr      <= 8'hA5;
`endif
    end else begin
      VOUT <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CFG_WE) begin
            case (CFG_SEL)
              3'd0:    b0 <= CFG_DATA;
              3'd1:    b1 <= CFG_DATA;
              3'd2:    b2 <= CFG_DATA;
              3'd3:    a1 <= CFG_DATA;
              3'd4:    a2 <= CFG_DATA;
              default: ;
            endcase
          end
          if (START) begin
            gap_q     <= GAP;
            idx       <= '0;
            gap_cnt   <= '0;
            drain_cnt <= '0;
            nsamp_q   <= nsamp_clamped;
`ifdef STIM_RANDGAP_EN
            lfsr      <= 8'hA5;
`endif
            state     <= (NSAMP == '0) ? S_DRAIN : S_PLAY;
          end
        end
        S_PLAY: begin
          BUSY <= 1'b1;
          if (gap_cnt == '0) begin
            VOUT    <= 1'b1;
            DOUT    <= mem[idx[AW-1:0]];
            gap_cnt <= gap_len;
            idx     <= idx + 1'b1;
`ifdef STIM_RANDGAP_EN
            lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
            // Last sample goes straight to drain; no trailing gap.
            if (idx == nsamp_q - 1'b1) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(DRAIN)) begin
            state   <= S_DONE;
            BUSY    <= 1'b0;
            END_SIM <= 1'b1;
          end else begin
            BUSY      <= 1'b1;
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stim_stream_gen.md
Name: stim_stream_gen

Overview:
- Synthesizable stimulus transmitter for the IIR filter input interface (VIN/DIN valid-qualified samples plus a1/a2/b0/b1/b2 coefficients).
- Holds a small sample RAM and a coefficient register file, both loaded through write ports.
- On START, plays the samples out with a programmable gap between them, then waits a drain period and raises END_SIM.
- Replaces the behavioural generator when the filter chain is prototyped on hardware or run in gate-level loops.

Parameters:
NB, 12, sample and coefficient width
DEPTH, 16, sample RAM depth (power of 2)
AW, 4, RAM address width (log2 DEPTH)
DRAIN, 8, idle cycles after the last sample before END_SIM (DRAIN >= 1)

Ports:
CLK  in  1  clock
RST_n  in  1  reset, synchronous, active-low
START  in  1  start playback; sampled in IDLE only
NSAMP  in  AW+1  samples to play; latched at START
GAP  in  4  idle cycles between consecutive samples; latched at START
LD_WE  in  1  sample RAM write enable
LD_ADDR  in  AW  sample RAM write address
LD_DATA  in  NB  sample RAM write data
CFG_WE  in  1  coefficient write enable
CFG_SEL  in  3  coefficient select: 0=b0 1=b1 2=b2 3=a1 4=a2; 5-7 ignored
CFG_DATA  in  NB  coefficient write data
VOUT  out  1  sample valid, one-cycle pulse per sample
DOUT  out  NB  sample data, registered
a1,a2,b0,b1,b2  out  NB each  coefficient registers
BUSY  out  1  high in PLAY and DRAIN
END_SIM  out  1  sticky end-of-stimulus flag

Behaviour:
- One clock (CLK). Reset is synchronous and active-low (RST_n); all state changes on the CLK rising edge.
- Reset values:
  - VOUT, DOUT, all coefficients, BUSY and END_SIM = 0.
  - State = IDLE.
  - RAM contents are not reset.
- States: IDLE -> PLAY -> DRAIN -> DONE.
- IDLE:
  - LD_WE writes the RAM; CFG_WE writes the selected coefficient.
  - START with NSAMP>0: latch min(NSAMP, DEPTH) and GAP, go to PLAY.
  - START with NSAMP=0: go straight to DRAIN.
- Writes that coincide with START are honoured. A RAM write to address 0 is visible to the first sample.
- LD_WE and CFG_WE are ignored in PLAY, DRAIN and DONE. RAM and coefficients stay frozen.
- Timing (START sampled at edge t):
  - Sample i drives VOUT=1, DOUT=mem[i] from edge t+1+i*(GAP+1).
  - VOUT is 0 on all other cycles. DOUT holds the last emitted value between pulses.
  - BUSY rises at edge t+1.
- After the last sample's valid cycle at edge L:
  - No trailing gap; DRAIN cycles occupy edges L+1..L+DRAIN.
  - At edge L+DRAIN+1: END_SIM=1, BUSY=0, state DONE.
- NSAMP=0: drain edges t+1..t+DRAIN; END_SIM at edge t+DRAIN+1.
- DONE: END_SIM stays high and START is ignored. Only reset leaves DONE.
- Reset mid-operation: next edge returns all outputs to reset values, state IDLE, RAM preserved.
- Internal counters:
  - Sample index: AW+1 bits.
  - Gap counter: 4 bits, plus 2 extra when the optional feature is compiled in.
  - Drain counter: sized from DRAIN.
  - No wrap is possible: NSAMP is clamped to DEPTH.

Optional Feature:
- Macro STIM_RANDGAP_EN.
- Defined:
  - 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1, seeded to 8'hA5 at reset and at START.
  - Each gap = GAP + lfsr[1:0].
  - LFSR advances once per emitted sample, on its valid cycle.
  - Identical runs give identical gap sequences.
- Undefined: gap is fixed at GAP; no LFSR logic is present.

Test Plan:
1. RST_n=0 for 3 cycles mid-random inputs -> VOUT, DOUT, coefficients, BUSY, END_SIM all 0; LD/CFG writes during reset have no effect.
2. Load mem[0..3] = 001,7FF,800,FFF and b0=0A0, a1=F60. Then START at t with NSAMP=4, GAP=0 -> VOUT high t+1..t+4 with those values in order; b0=0A0, a1=F60; END_SIM at t+13 (DRAIN=8).
3. NSAMP=3, GAP=2 -> VOUT only at t+1, t+4, t+7; DOUT steady between pulses; END_SIM at t+16.
4. NSAMP=20 (DEPTH=16) -> exactly 16 pulses. NSAMP=0 -> no pulse, END_SIM at t+9.
5. LD_WE to addr 1 and CFG_WE to b1 during PLAY -> RAM and b1 unchanged. Reset after the 2nd pulse, then START again -> original RAM data replayed from mem[0]; coefficients read 0 until rewritten.
6. With STIM_RANDGAP_EN, GAP=1, NSAMP=8 -> every inter-pulse spacing is in 2..5 cycles; the spacing sequence is identical across two reset+START runs. Without the macro, spacing is always 2.
